bit_serial_alu_seq: RTL and testbench
=====================================

Name: bit_serial_alu_seq

Overview:
Sequencer that drives a single external bitSlice over WIDTH clock cycles, LSB first, to give a WIDTH-bit serial ALU. It sits directly upstream of the bitSlice instance. Each cycle it presents one operand bit pair and the running carry to the slice, then consumes the slice's r1/c_out. It also assembles the result word and the carry/overflow flags and hands them to the register file under a start/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while ready=1
op  input  3  ALU opcode, latched on accepted start
a  input  WIDTH  operand A (to slice r2)
b  input  WIDTH  operand B (to slice r3)
ready  output  1  high in IDLE and DONE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  assembled result, held until next accepted start
carry_out  output  1  final slice c_out
overflow  output  1  signed overflow, ADD/SUB only
slice_r2  output  1  current A bit to slice
slice_r3  output  1  current B bit to slice
slice_c_in  output  1  running carry to slice
slice_op  output  3  latched op to slice ALUop
slice_r1  input  1  slice result bit
slice_c_out  input  1  slice carry out

Behaviour:
- Clock is one clock, clk; reset is synchronous and active-high, rst.
- Reset: state=IDLE. ready=1. done=0. result=0. carry_out=0. overflow=0. All slice_* outputs = 0. Internal shift registers and counter = 0.
- Reset mid-RUN abandons the operation. No done pulse is produced.
- FSM states:
  - IDLE: start=1 latches a, b, op into shift regs. Sets cnt=0 and carry=seed(op). Goes to RUN.
  - RUN: slice_r2=a_sh[0], slice_r3=b_sh[0], slice_c_in=carry, slice_op=op_q (all combinational from registers). Each cycle:
    - result_sh shifts right, with slice_r1 entering at MSB.
    - carry <= slice_c_out.
    - a_sh and b_sh shift right.
    - cnt++.
    - At cnt==WIDTH-1, go to DONE.
  - DONE: done=1 for exactly this cycle. result=result_sh, carry_out=final carry. start=1 here is accepted as in IDLE (back-to-back). Otherwise go to IDLE.
- seed(op) = 1 for ALU_SUB, 0 otherwise. The slice inverts r3 for SUB.
- overflow = (carry into MSB) XOR (carry out of MSB) for ADD/SUB; forced to 0 for all other ops. The carry into the MSB is captured at cnt==WIDTH-1.
- carry_out is the raw final slice_c_out for every op.
- Latency: start accepted on edge 0; done is high during the cycle after edge WIDTH, i.e. WIDTH+1 cycles from start to done.
- start while ready=0 is ignored. a, b and op may change freely during RUN without effect.
- result, carry_out and overflow hold their values through IDLE until the next accepted start. They are not cleared by DONE→IDLE.
- slice_* outputs in IDLE/DONE are 0.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams: ALU_MOV=3'b000, ALU_NOT=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_OR=3'b100, ALU_AND=3'b101, ALU_XOR=3'b110, ALU_NOR=3'b111.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- No internal sub-module; bitSlice is instantiated alongside in the parent wrapper bit_serial_alu. This lets the same sequencer be run against both the gate-level slice and the behavioural slice.

Test Plan (WIDTH=8, sequencer wired to bitSlice):
- ADD a=8'h7F, b=8'h01, start 1 cycle → done pulse 9 cycles later; result=8'h80, carry_out=0, overflow=1.
- SUB a=8'h05, b=8'h07 → result=8'hFE, carry_out=0, overflow=0. SUB a=8'h80, b=8'h01 → result=8'h7F, overflow=1.
- AND a=8'hF0, b=8'h3C → result=8'h30, overflow=0. Then XOR of the same operands → 8'hCC.
- start pulsed again on cycle 3 of RUN with different operands → ignored; result is unchanged from the first op, and only one done pulse occurs.
- rst asserted on cycle 4 of RUN → next cycle: ready=1, result=0, no done. A fresh ADD 8'h01+8'h01 then yields 8'h02.
- Back-to-back: start held high in the DONE cycle with ADD 8'hFF+8'h01 → second op begins immediately; result=8'h00, carry_out=1, overflow=0, done 9 cycles after the DONE cycle.

Source files
------------

// File: rtl/bit_serial_alu_seq_pkg.sv
// alu_pkg: opcodes, sequencer state encoding and carry-seed helper shared by the serial ALU
package alu_pkg;
  localparam logic [2:0] ALU_MOV = 3'b000;
  localparam logic [2:0] ALU_NOT = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic logic is_arith(input logic [2:0] op);
    return op == ALU_ADD || op == ALU_SUB;
  endfunction
  // subtraction is a + ~b + 1; the slice inverts b, the +1 comes from the seed
  function automatic logic seed(input logic [2:0] op);
    return op == ALU_SUB;
  endfunction
endpackage

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: drives one external bit slice LSB-first over WIDTH cycles to form a WIDTH-bit ALU
// ports: clk/rst; start/op/a/b request with ready/done handshake; result/carry_out/overflow held
// until replaced; slice_r2/r3/c_in/op feed the slice, slice_r1/c_out come back from it
module bit_serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             slice_r2,
  output logic             slice_r3,
  output logic             slice_c_in,
  output logic [2:0]       slice_op,
  input  logic             slice_r1,
  input  logic             slice_c_out
);
  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             run, accept, last;
  logic [WIDTH-1:0] res_nxt;
  // res_sh holds only the upper WIDTH-1 bits; the live slice bit completes the word
  assign res_nxt    = {slice_r1, res_sh};
  assign run        = state == RUN;
  assign ready      = state == IDLE || state == DONE;
  assign done       = state == DONE;
  assign accept     = start && ready;
  assign last       = run && cnt == CNT_W'(WIDTH - 1);
  assign slice_r2   = run & a_sh[0];
  assign slice_r3   = run & b_sh[0];
  assign slice_c_in = run & carry;
  assign slice_op   = run ? op_q : 3'b000;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      op_q      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      state  <= RUN;
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      op_q   <= op;
      cnt    <= '0;
      carry  <= seed(op);
    end else if (run) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt[WIDTH-1:1];
      cnt    <= cnt + 1'b1;
      carry  <= slice_c_out;
      if (last) begin
        state     <= DONE;
        result    <= res_nxt;
        carry_out <= slice_c_out;
        // carry still holds the carry into the MSB on this final step
        overflow  <= is_arith(op_q) & (carry ^ slice_c_out);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: scoreboard bench for the serial ALU sequencer with a behavioural bit slice
module tb_bit_serial_alu_seq;
  import alu_pkg::*;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           t;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done, carry_out, overflow;
  logic [W-1:0] result;
  logic         s_r2, s_r3, s_cin, s_r1, s_cout, bb, cy;
  logic [2:0]   s_op;
  exp_t         q[$];
  exp_t         e;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow),
    .slice_r2(s_r2), .slice_r3(s_r3), .slice_c_in(s_cin), .slice_op(s_op),
    .slice_r1(s_r1), .slice_c_out(s_cout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    bb     = s_op == ALU_SUB ? ~s_r3 : s_r3;
    cy     = (s_r2 & bb) | (s_cin & (s_r2 ^ bb));
    s_cout = (s_op == ALU_ADD || s_op == ALU_SUB) ? cy : 1'b0;
    s_r1   = s_op == ALU_MOV ? s_r2 :
             s_op == ALU_NOT ? ~s_r2 :
             s_op == ALU_OR  ? s_r2 | s_r3 :
             s_op == ALU_AND ? s_r2 & s_r3 :
             s_op == ALU_XOR ? s_r2 ^ s_r3 :
             s_op == ALU_NOR ? ~(s_r2 | s_r3) : s_r2 ^ bb ^ s_cin;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("carry_out", 32'(carry_out), 32'(e.c));
        chk("overflow", 32'(overflow), 32'(e.v));
        chk("done_cycle", cyc, e.t);
      end
    end
  end
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ec, input logic ev);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    q.push_back('{er, ec, ev, cyc + 1 + W});
    @(negedge clk);
    start = 1'b0;
    op = ~o;
    a = ~x;
    b = ~y;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL done_timeout: got no done in 40 cycles expected a done pulse");
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
    chk("rst_slice", {26'd0, s_r2, s_r3, s_cin, s_op}, 32'd0);
    rst = 1'b0;
    issue(ALU_MOV, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0); wait_done();
    issue(ALU_NOT, 8'hA5, 8'h00, 8'h5A, 1'b0, 1'b0); wait_done();
    issue(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1); wait_done();
    issue(ALU_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0); wait_done();
    issue(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1); wait_done();
    issue(ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0); wait_done();
    issue(ALU_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0); wait_done();
    issue(ALU_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0); wait_done();
    issue(ALU_NOR, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0); wait_done();
    @(negedge clk);
    chk("idle_hold_result", 32'(result), 32'h03);
    chk("idle_ready", 32'(ready), 32'd1);
    issue(ALU_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("run_ready", 32'(ready), 32'd0);
    start = 1'b1;
    op = ALU_SUB;
    a = 8'hFF;
    b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("ignored_start_result", 32'(result), 32'h46);
    issue(ALU_ADD, 8'h55, 8'h11, 8'h66, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_slice", {26'd0, s_r2, s_r3, s_cin, s_op}, 32'd0);
    rst = 1'b0;
    issue(ALU_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0); wait_done();
    issue(ALU_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0); wait_done();
    start = 1'b1;
    op = ALU_ADD;
    a = 8'hFF;
    b = 8'h01;
    q.push_back('{8'h00, 1'b1, 1'b0, cyc + 1 + W});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_running", 32'(ready), 32'd0);
    wait_done();
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
